// File: rtl/vm_pkg.sv
// Shared definitions for the multi-product vending machine: coin codes,
// coin values and the controller state encoding.
package vm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_VEND    = 2'd2,
    ST_CHANGE  = 2'd3
  } state_t;

  localparam logic [2:0] COIN_NONE    = 3'd0;
  localparam logic [2:0] COIN_NICKEL  = 3'd1;
  localparam logic [2:0] COIN_DIME    = 3'd2;
  localparam logic [2:0] COIN_QUARTER = 3'd3;

  localparam int VAL_NICKEL  = 5;
  localparam int VAL_DIME    = 10;
  localparam int VAL_QUARTER = 25;

endpackage

// File: rtl/vm_change_picker.sv
// Combinational coin helper: picks the largest coin not exceeding the credit
// (for change return) and decodes an incoming coin code into its value.
module vm_change_picker
  import vm_pkg::*;
#(
  parameter int CREDIT_W = 8
) (
  input  logic [CREDIT_W-1:0] credit_i,
  input  logic [2:0]          code_i,
  output logic [2:0]          pick_code_o,
  output logic [CREDIT_W-1:0] pick_value_o,
  output logic                code_valid_o,
  output logic [CREDIT_W-1:0] code_value_o
);

  // Largest-first coin selection; no coin when credit is zero.
  always_comb begin
    pick_code_o  = COIN_NONE;
    pick_value_o = '0;
    if (credit_i >= CREDIT_W'(VAL_QUARTER)) begin
      pick_code_o  = COIN_QUARTER;
      pick_value_o = CREDIT_W'(VAL_QUARTER);
    end else if (credit_i >= CREDIT_W'(VAL_DIME)) begin
      pick_code_o  = COIN_DIME;
      pick_value_o = CREDIT_W'(VAL_DIME);
    end else if (credit_i >= CREDIT_W'(VAL_NICKEL)) begin
      pick_code_o  = COIN_NICKEL;
      pick_value_o = CREDIT_W'(VAL_NICKEL);
    end
  end

  // Value decode of the coin acceptor code; "none" and codes 4-7 are not valid coins.
  always_comb begin
    code_valid_o = 1'b1;
    code_value_o = '0;
    case (code_i)
      COIN_NICKEL:  code_value_o = CREDIT_W'(VAL_NICKEL);
      COIN_DIME:    code_value_o = CREDIT_W'(VAL_DIME);
      COIN_QUARTER: code_value_o = CREDIT_W'(VAL_QUARTER);
      default:      code_valid_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/vending_machine_multi.sv
// Multi-product vending controller: collects coins into a credit register,
// vends priced items against per-item stock, and returns change one coin
// per cycle, largest first.
//
// state      | meaning
// ST_IDLE    | no credit held
// ST_COLLECT | credit > 0, accepting coins / purchase / cancel
// ST_VEND    | single cycle, vend pulse on the outputs
// ST_CHANGE  | returning remaining credit, one coin per cycle
module vending_machine_multi
  import vm_pkg::*;
#(
  parameter int                          N_ITEMS    = 4,
  parameter int                          SEL_W      = $clog2(N_ITEMS),
  parameter int                          CREDIT_W   = 8,
  parameter int                          MAX_CREDIT = 200,
  parameter logic [N_ITEMS*CREDIT_W-1:0] PRICES     = {8'd50, 8'd40, 8'd30, 8'd25},
  parameter int                          STOCK_W    = 4,
  parameter int                          STOCK_MAX  = 15
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [2:0]          in,
  input  logic [SEL_W-1:0]    sel,
  input  logic                sel_valid,
  input  logic                cancel,
  input  logic                restock,
  output logic                out,
  output logic [SEL_W-1:0]    out_item,
  output logic [2:0]          change,
  output logic [CREDIT_W-1:0] credit,
  output logic                busy,
  output logic                coin_reject,
  output logic                sold_out,
  output logic                short_credit
);

  state_t                state_q, state_d;
  logic [CREDIT_W-1:0]   credit_q, credit_d;
  logic [STOCK_W-1:0]    stock_q [N_ITEMS];
  logic [STOCK_W-1:0]    stock_d [N_ITEMS];
  logic                  out_q, out_d;
  logic [SEL_W-1:0]      out_item_q, out_item_d;
  logic [2:0]            change_q, change_d;
  logic                  busy_q, busy_d;
  logic                  coin_reject_q, coin_reject_d;
  logic                  sold_out_q, sold_out_d;
  logic                  short_credit_q, short_credit_d;

  logic [2:0]            pick_code;
  logic [CREDIT_W-1:0]   pick_value;
  logic                  coin_valid;
  logic [CREDIT_W-1:0]   coin_value;

  logic                  idle_like;
  logic                  sel_in_range;
  logic [CREDIT_W-1:0]   price_sel;
  logic [STOCK_W-1:0]    stock_sel;
  logic                  cancel_req;
  logic                  sel_req;
  logic                  vend_ok;
  logic [CREDIT_W:0]     coin_sum;
  logic                  coin_ok;

  vm_change_picker #(.CREDIT_W(CREDIT_W)) u_picker (
    .credit_i     (credit_q),
    .code_i       (in),
    .pick_code_o  (pick_code),
    .pick_value_o (pick_value),
    .code_valid_o (coin_valid),
    .code_value_o (coin_value)
  );

  // Request qualification shared by next-state and datapath logic.
  // Cancel outranks a purchase, which outranks a coin.
  assign idle_like    = (state_q == ST_IDLE) || (state_q == ST_COLLECT);
  assign sel_in_range = int'(sel) < N_ITEMS;
  assign price_sel    = PRICES[int'(sel)*CREDIT_W +: CREDIT_W];
  assign stock_sel    = sel_in_range ? stock_q[sel] : '0;
  assign cancel_req   = idle_like && cancel;
  assign sel_req      = idle_like && !cancel && sel_valid && sel_in_range;
  assign vend_ok      = sel_req && (stock_sel != '0) && (credit_q >= price_sel);
  assign coin_sum     = {1'b0, credit_q} + {1'b0, coin_value};
  assign coin_ok      = idle_like && !cancel && !sel_valid && coin_valid &&
                        (coin_sum <= (CREDIT_W+1)'(MAX_CREDIT));

  // State and registered outputs; reset is synchronous and active-low.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q        <= ST_IDLE;
      credit_q       <= '0;
      out_q          <= 1'b0;
      out_item_q     <= '0;
      change_q       <= COIN_NONE;
      busy_q         <= 1'b0;
      coin_reject_q  <= 1'b0;
      sold_out_q     <= 1'b0;
      short_credit_q <= 1'b0;
      for (int i = 0; i < N_ITEMS; i++) stock_q[i] <= STOCK_W'(STOCK_MAX);
    end else begin
      state_q        <= state_d;
      credit_q       <= credit_d;
      out_q          <= out_d;
      out_item_q     <= out_item_d;
      change_q       <= change_d;
      busy_q         <= busy_d;
      coin_reject_q  <= coin_reject_d;
      sold_out_q     <= sold_out_d;
      short_credit_q <= short_credit_d;
      stock_q        <= stock_d;
    end
  end

  // Next-state selection.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE, ST_COLLECT: begin
        if (cancel_req) begin
          if (state_q == ST_COLLECT) state_d = ST_CHANGE;
        end else if (vend_ok) begin
          state_d = ST_VEND;
        end else if (coin_ok) begin
          state_d = ST_COLLECT;
        end
      end
      ST_VEND:   state_d = (credit_q != '0) ? ST_CHANGE : ST_IDLE;
      ST_CHANGE: if (credit_q == '0) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Datapath and next output values, registered alongside the state.
  always_comb begin
    credit_d       = credit_q;
    stock_d        = stock_q;
    out_d          = 1'b0;
    out_item_d     = out_item_q;
    change_d       = COIN_NONE;
    coin_reject_d  = (in != COIN_NONE) && !coin_ok;
    sold_out_d     = sel_req && (stock_sel == '0);
    short_credit_d = sel_req && (stock_sel != '0) && (credit_q < price_sel);
    busy_d         = (state_d == ST_VEND) || (state_d == ST_CHANGE);

    // Every entry into or stay in CHANGE carries a nonzero credit, so a coin
    // is always emitted on that edge and the register shows the remainder.
    if (state_d == ST_CHANGE) begin
      change_d = pick_code;
      credit_d = credit_q - pick_value;
    end else if (vend_ok) begin
      out_d          = 1'b1;
      out_item_d     = sel;
      credit_d       = credit_q - price_sel;
      stock_d[sel]   = stock_q[sel] - STOCK_W'(1);
    end else if (coin_ok) begin
      credit_d = coin_sum[CREDIT_W-1:0];
    end

    if (restock) begin
      for (int i = 0; i < N_ITEMS; i++) stock_d[i] = STOCK_W'(STOCK_MAX);
    end
  end

  assign out          = out_q;
  assign out_item     = out_item_q;
  assign change       = change_q;
  assign credit       = credit_q;
  assign busy         = busy_q;
  assign coin_reject  = coin_reject_q;
  assign sold_out     = sold_out_q;
  assign short_credit = short_credit_q;

endmodule

// File: tb/tb_vending_machine_multi.sv
// Scoreboard bench for vending_machine_multi: the stimulus side runs a
// transaction-level model and queues the expected outputs for the next
// cycle; a monitor pops and compares one entry per observed cycle.
module tb_vending_machine_multi;

  typedef struct packed {
    logic       out;
    logic [1:0] out_item;
    logic [2:0] change;
    logic [7:0] credit;
    logic       busy;
    logic       coin_reject;
    logic       sold_out;
    logic       short_credit;
  } exp_t;

  typedef struct {
    int change;
    int credit;
    bit busy;
  } step_t;

  logic       clk;
  logic       rst;
  logic [2:0] coin;
  logic [1:0] sel;
  logic       sel_valid;
  logic       cancel;
  logic       restock;
  logic       vend;
  logic [1:0] vend_item;
  logic [2:0] chg;
  logic [7:0] cred;
  logic       busy;
  logic       rej;
  logic       so;
  logic       sc;

  int n_checks = 0;
  int n_fail   = 0;

  exp_t  exp_q[$];
  step_t plan[$];
  int    m_credit;
  int    m_stock[4];
  int    m_item;
  int    prices[4] = '{25, 30, 40, 50};

  vending_machine_multi dut (
    .clk          (clk),
    .rst          (rst),
    .in           (coin),
    .sel          (sel),
    .sel_valid    (sel_valid),
    .cancel       (cancel),
    .restock      (restock),
    .out          (vend),
    .out_item     (vend_item),
    .change       (chg),
    .credit       (cred),
    .busy         (busy),
    .coin_reject  (rej),
    .sold_out     (so),
    .short_credit (sc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Greedy change list for an amount, followed by the idle cycle that ends it.
  task automatic build_plan(input int amount);
    step_t p;
    int r;
    r = amount;
    while (r > 0) begin
      if (r >= 25) begin p.change = 3; r -= 25; end
      else if (r >= 10) begin p.change = 2; r -= 10; end
      else begin p.change = 1; r -= 5; end
      p.credit = r;
      p.busy   = 1'b1;
      plan.push_back(p);
    end
    p.change = 0;
    p.credit = 0;
    p.busy   = 1'b0;
    plan.push_back(p);
  endtask

  task automatic model_step(input logic r, input logic [2:0] c, input logic [1:0] s,
                            input logic sv, input logic cn, input logic rs);
    exp_t  e;
    step_t p;
    int    val;
    int    si;
    e = '0;
    if (!r) begin
      m_credit = 0;
      m_item   = 0;
      plan.delete();
      for (int i = 0; i < 4; i++) m_stock[i] = 15;
      exp_q.push_back(e);
      return;
    end
    e.out_item = m_item[1:0];
    val = (c == 3'd1) ? 5 : (c == 3'd2) ? 10 : (c == 3'd3) ? 25 : 0;
    si  = int'(s);
    if (plan.size() > 0) begin
      p = plan.pop_front();
      m_credit      = p.credit;
      e.change      = p.change[2:0];
      e.busy        = p.busy;
      e.coin_reject = (c != 3'd0);
    end else if (cn) begin
      e.coin_reject = (c != 3'd0);
      if (m_credit > 0) begin
        build_plan(m_credit);
        p = plan.pop_front();
        m_credit = p.credit;
        e.change = p.change[2:0];
        e.busy   = 1'b1;
      end
    end else if (sv) begin
      e.coin_reject = (c != 3'd0);
      if (m_stock[si] == 0) e.sold_out = 1'b1;
      else if (m_credit < prices[si]) e.short_credit = 1'b1;
      else begin
        m_credit -= prices[si];
        m_stock[si] -= 1;
        m_item     = si;
        e.out      = 1'b1;
        e.out_item = s;
        e.busy     = 1'b1;
        build_plan(m_credit);
      end
    end else if (c != 3'd0) begin
      if (val > 0 && m_credit + val <= 200) m_credit += val;
      else e.coin_reject = 1'b1;
    end
    if (rs) for (int i = 0; i < 4; i++) m_stock[i] = 15;
    e.credit = m_credit[7:0];
    exp_q.push_back(e);
  endtask

  task automatic cyc(input logic r, input logic [2:0] c, input logic [1:0] s,
                     input logic sv, input logic cn, input logic rs);
    @(negedge clk);
    rst = r; coin = c; sel = s; sel_valid = sv; cancel = cn; restock = rs;
    model_step(r, c, s, sv, cn, rs);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b1, 3'd0, 2'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic coin_in(input logic [2:0] c);
    cyc(1'b1, c, 2'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic buy(input logic [1:0] s);
    cyc(1'b1, 3'd0, s, 1'b1, 1'b0, 1'b0);
  endtask

  // Monitor: one expected entry per cycle, compared just after the edge.
  initial begin
    exp_t e;
    exp_t got;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        got = {vend, vend_item, chg, cred, busy, rej, so, sc};
        n_checks++;
        if (got !== e) begin
          n_fail++;
          $display("FAIL outputs t=%0t got out=%0b item=%0d chg=%0d cr=%0d busy=%0b rej=%0b so=%0b sc=%0b required out=%0b item=%0d chg=%0d cr=%0d busy=%0b rej=%0b so=%0b sc=%0b",
                   $time, got.out, got.out_item, got.change, got.credit, got.busy,
                   got.coin_reject, got.sold_out, got.short_credit,
                   e.out, e.out_item, e.change, e.credit, e.busy,
                   e.coin_reject, e.sold_out, e.short_credit);
        end
      end
    end
  end

  initial begin
    rst = 1'b0; coin = 3'd0; sel = 2'd0; sel_valid = 1'b0; cancel = 1'b0; restock = 1'b0;

    cyc(1'b0, 3'd0, 2'd0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 3'd0, 2'd0, 1'b0, 1'b0, 1'b0);
    idle(1);

    // three dimes, buy item 0, one nickel back
    coin_in(3'd2); coin_in(3'd2); coin_in(3'd2);
    buy(2'd0);
    idle(4);

    // exact payment for item 3
    coin_in(3'd3); coin_in(3'd3);
    buy(2'd3);
    idle(3);

    // short credit, then cancel returns the dime
    coin_in(3'd2);
    buy(2'd2);
    cyc(1'b1, 3'd0, 2'd0, 1'b0, 1'b1, 1'b0);
    idle(3);

    // fill to the credit ceiling, overflow coin, cancel
    for (int i = 0; i < 9; i++) coin_in(3'd3);
    cyc(1'b1, 3'd0, 2'd0, 1'b0, 1'b1, 1'b0);
    idle(11);

    // exhaust item 1, sold out, restock, buy again
    for (int i = 0; i < 15; i++) begin
      coin_in(3'd3); coin_in(3'd1);
      buy(2'd1);
      idle(2);
    end
    coin_in(3'd3); coin_in(3'd1);
    buy(2'd1);
    cyc(1'b1, 3'd0, 2'd0, 1'b0, 1'b0, 1'b1);
    buy(2'd1);
    idle(3);

    // coins and an invalid code during change, then reset mid-change
    for (int i = 0; i < 4; i++) coin_in(3'd3);
    cyc(1'b1, 3'd0, 2'd0, 1'b0, 1'b1, 1'b0);
    coin_in(3'd1);
    coin_in(3'd5);
    cyc(1'b0, 3'd3, 2'd0, 1'b0, 1'b0, 1'b0);
    idle(3);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      int          rc;
      logic [2:0]  c;
      logic        r;
      rc = int'($urandom_range(0, 99));
      if (rc < 45)      c = 3'($urandom_range(1, 3));
      else if (rc < 50) c = 3'($urandom_range(4, 7));
      else              c = 3'd0;
      r = ($urandom_range(0, 599) != 0);
      cyc(r, c, 2'($urandom_range(0, 3)),
          $urandom_range(0, 99) < 15,
          $urandom_range(0, 99) < 4,
          $urandom_range(0, 199) < 1);
    end
    idle(2);

    for (int i = 0; i < 20; i++) begin
      if (exp_q.size() == 0) break;
      @(posedge clk);
    end
    #2;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain got %0d entries left required 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vending_machine_multi.md
# vending_machine_multi

Parametrised multi-product successor to the single-price 25-unit vending machine. It accepts nickel/dime/quarter coins and holds a running credit. It serves one of `N_ITEMS` products at individual prices with per-item stock counters, and returns change one coin per cycle, largest coin first. It sits between the coin-acceptor decoder and the dispenser/coin-hopper drivers.

## Interface
- `N_ITEMS`, 4: number of products; `SEL_W = $clog2(N_ITEMS)`.
- `CREDIT_W`, 8: credit register width.
- `MAX_CREDIT`, 200: coins that would push credit above this are rejected.
- `PRICES`, {8'd50,8'd40,8'd30,8'd25}: packed `N_ITEMS×CREDIT_W`; item 0 in the LSBs. Every price is a nonzero multiple of 5.
- `STOCK_W`, 4: stock counter width.
- `STOCK_MAX`, 15: stock value after reset or restock.
- `clk`, in, 1: single clock, rising edge.
- `rst`, in, 1: synchronous, active-low reset.
- `in`, in, 3: coin code. 0 = none, 1 = nickel (5), 2 = dime (10), 3 = quarter (25), 4–7 = invalid.
- `sel`, in, SEL_W: product index.
- `sel_valid`, in, 1: purchase request, one cycle.
- `cancel`, in, 1: refund request.
- `restock`, in, 1: reload all stock counters.
- `out`, out, 1: vend pulse.
- `out_item`, out, SEL_W: product vended; valid when `out`=1.
- `change`, out, 3: coin being returned this cycle, same encoding as `in`; 0 = none.
- `credit`, out, CREDIT_W: current credit.
- `busy`, out, 1: high in VEND and CHANGE.
- `coin_reject`, out, 1: pulse; the coin presented in the previous cycle was not accepted.
- `sold_out`, out, 1: pulse; the selected item had zero stock.
- `short_credit`, out, 1: pulse; credit was below the selected item's price.

## Operation
- States:
  - IDLE: credit = 0.
  - COLLECT: credit > 0.
  - VEND: one cycle.
  - CHANGE: returning credit.
- Priority in IDLE/COLLECT, per cycle: cancel > sel_valid > coin.
- A coin presented in the same cycle as an accepted cancel or sel_valid is rejected.
- Coin accept: valid code, no cancel/sel_valid, and `credit + value ≤ MAX_CREDIT`. Credit += value and the state goes to COLLECT.
- Coin reject cases, each giving `coin_reject`=1 next cycle with credit unchanged:
  - invalid code;
  - overflow past MAX_CREDIT;
  - coin while `busy`.
- sel_valid when `sel ≥ N_ITEMS`: ignored, no flags.
- sel_valid with stock[sel] = 0: `sold_out` pulse; credit and state unchanged.
- sel_valid with credit < PRICES[sel] and stock > 0: `short_credit` pulse; credit and state unchanged.
- sel_valid with stock > 0 and credit ≥ price:
  - go to VEND;
  - credit −= price;
  - stock[sel] −= 1.
- VEND lasts exactly one cycle. Exit goes to CHANGE if the remaining credit > 0, else IDLE.
- cancel in COLLECT goes to CHANGE. cancel in IDLE is a no-op.
- CHANGE: each cycle emit the largest coin ≤ credit (25, then 10, then 5) and subtract its value. When credit reaches 0, go to IDLE with `change`=0.
- sel_valid and cancel are ignored while busy.
- restock: accepted in any state. All stock counters go to STOCK_MAX next cycle. It overrides a same-cycle decrement.
- Credit is always a multiple of 5, so CHANGE always terminates with credit exactly 0.

## Timing
- All outputs are registered.
- Reset values:
  - `out`=0, `out_item`=0, `change`=0, `credit`=0;
  - `busy`=0, `coin_reject`=0, `sold_out`=0, `short_credit`=0;
  - state IDLE, all stock = STOCK_MAX.
- Coin presented on edge k: `credit` reflects it after edge k (visible in cycle k+1).
- sel_valid accepted on edge k:
  - `out`=1 and `out_item` valid in cycle k+1;
  - `credit` already reduced in cycle k+1;
  - first `change` coin in cycle k+2.
- Change latency: ceil-greedy coin count in cycles; one coin per cycle, no gaps.
- `busy` is high from the cycle after acceptance through the last change coin. It is low in the cycle `change` returns to 0.
- Reset mid-CHANGE or mid-VEND: remaining credit is discarded and all outputs take their reset values on that edge.

## Structure
- Shared package `vm_pkg`:
  - coin codes COIN_NONE/NICKEL/DIME/QUARTER;
  - coin values 5/10/25;
  - state encoding.
- Sub-module `vm_change_picker`: combinational; credit → (coin code, coin value), largest-first. Also reused for the value decode of `in`.
- The stock counter array is a register array inside the top level.

## Test plan
- Reset, then three dimes, then sel=0 (price 25):
  - credit 10 → 20 → 30;
  - `out`=1 with `out_item`=0;
  - then one `change`=1 (nickel);
  - then IDLE, credit 0.
- Quarter, quarter, sel=3 (price 50): `out`=1, no change, `busy` low 1 cycle after VEND.
- Dime, then sel=2 (price 40): `short_credit` pulse, credit stays 10. Then cancel → `change`=2 for one cycle, credit 0.
- 8 quarters (credit 200), then a 9th quarter: `coin_reject` pulse, credit stays 200. Then cancel → eight `change`=3 in consecutive cycles.
- Buy item 1 fifteen times (30 each, exact coins), then a 16th request: `sold_out` pulse. Then restock, then the purchase succeeds.
- Coins, or in=5, during CHANGE: `coin_reject` each time, change sequence unaffected. Then `rst`=0 mid-CHANGE: all outputs 0, credit 0 next cycle.
